// File: rtl/invalidopcode_simon_encrypt.sv
// invalidopcode_simon_encrypt: nibble-serial Simon 32/64 encryptor.
// Nibbles enter sr[95:0] = {x, y, k3, k2, k1, k0} MSB-first while `shift` is high.
// Dropping `shift` starts the rounds, which use an on-the-fly key schedule.
// When the rounds finish, the ciphertext replaces the block field of sr and the
// key field keeps the original key.
// Optional build macro SIMON_ENC_UNROLL2_EN: two rounds per clock (16-cycle busy).
module invalidopcode_simon_encrypt (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       shift,
    input  logic [3:0] data_in,
    output logic [3:0] data_out,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

    // z0 sequence; element i (leftmost = 0) sits at bit 61-i
    localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;

`ifdef SIMON_ENC_UNROLL2_EN
    localparam logic [4:0] RC_LAST = 5'd15;
`else
    localparam logic [4:0] RC_LAST = 5'd31;
`endif

    state_t      state_q, state_d;
    logic [95:0] sr_q, sr_d;
    logic [15:0] x_q, x_d, y_q, y_d;
    logic [63:0] kw_q, kw_d;      // {kw[3], kw[2], kw[1], kw[0]}
    logic [4:0]  rc_q, rc_d;
    logic [5:0]  zi_q, zi_d;
    logic        busy_q, busy_d, done_q, done_d;

    logic [15:0] x1, y1, xn, yn;
    logic [63:0] kw1, kwn;
    logic [5:0]  zi1, zin;

    function automatic logic [31:0] round_f(input logic [15:0] x, input logic [15:0] y,
                                            input logic [15:0] k);
        logic [15:0] f;
        f = ({x[14:0], x[15]} & {x[7:0], x[15:8]}) ^ {x[13:0], x[15:14]};
        return {y ^ f ^ k, x};
    endfunction

    // One key-schedule step: appends a new word and drops kw[0]
    function automatic logic [63:0] ks_step(input logic [63:0] kw, input logic zb);
        logic [15:0] t;
        t = {kw[50:48], kw[63:51]} ^ kw[31:16];
        t = t ^ {t[0], t[15:1]};
        return {~kw[15:0] ^ t ^ {15'd0, zb} ^ 16'd3, kw[63:16]};
    endfunction

    function automatic logic zbit(input logic [5:0] i);
        return Z0[6'd61 - i];
    endfunction

    function automatic logic [5:0] zinc(input logic [5:0] i);
        return (i == 6'd61) ? 6'd0 : i + 6'd1;
    endfunction

    // Round datapath: one or two rounds and key steps from the current state
    always_comb begin
        {x1, y1} = round_f(x_q, y_q, kw_q[15:0]);
        kw1      = ks_step(kw_q, zbit(zi_q));
        zi1      = zinc(zi_q);
`ifdef SIMON_ENC_UNROLL2_EN
        {xn, yn} = round_f(x1, y1, kw1[15:0]);
        kwn      = ks_step(kw1, zbit(zi1));
        zin      = zinc(zi1);
`else
        xn       = x1;
        yn       = y1;
        kwn      = kw1;
        zin      = zi1;
`endif
    end

    // Next-state logic: shifting, copy into working registers, rounds, write-back
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        x_d     = x_q;
        y_d     = y_q;
        kw_d    = kw_q;
        rc_d    = rc_q;
        zi_d    = zi_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (shift) begin
                    sr_d    = {sr_q[91:0], data_in};
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (shift) begin
                    sr_d = {sr_q[91:0], data_in};
                end else begin
                    // A partial load is fine: whatever sr holds gets encrypted
                    x_d     = sr_q[95:80];
                    y_d     = sr_q[79:64];
                    kw_d    = sr_q[63:0];
                    rc_d    = 5'd0;
                    zi_d    = 6'd0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // shift is ignored here; data_in is discarded
                x_d  = xn;
                y_d  = yn;
                kw_d = kwn;
                zi_d = zin;
                rc_d = rc_q + 5'd1;
                if (rc_q == RC_LAST) begin
                    sr_d    = {xn, yn, sr_q[63:0]};
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // State registers; reset aborts any run in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sr_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            kw_q    <= '0;
            rc_q    <= '0;
            zi_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            x_q     <= x_d;
            y_q     <= y_d;
            kw_q    <= kw_d;
            rc_q    <= rc_d;
            zi_q    <= zi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign data_out = sr_q[95:92];
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_invalidopcode_simon_encrypt.sv
// Scoreboard bench for invalidopcode_simon_encrypt: the stimulus pushes the expected
// results, and a monitor checks the busy length, the ciphertext, the key and the
// loopback decryption of each completed block.
module tb_invalidopcode_simon_encrypt;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       shift = 1'b0;
    logic [3:0] data_in = 4'd0;
    logic [3:0] data_out;
    logic       busy, done;

    invalidopcode_simon_encrypt dut (
        .clk(clk), .rst_n(rst_n), .shift(shift), .data_in(data_in),
        .data_out(data_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

`ifdef SIMON_ENC_UNROLL2_EN
    localparam int BUSY_CYC = 16;
`else
    localparam int BUSY_CYC = 32;
`endif
    localparam logic [63:0] KEY = 64'h1918_1110_0908_0100;
    localparam logic [31:0] PT1 = 32'h6565_6877;
    localparam logic [31:0] CT1 = 32'hc69b_e9bb;
    localparam logic [61:0] ZSEQ = 62'b11111010001001010110000111001101111101000100101011000011100110;

    typedef struct {
        logic [31:0] pt;
        logic [63:0] key;
        logic [31:0] ct;
        int          busy;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, act, req);
        end
    endtask

    // Reference model: full key expansion, then the plain round loop
    function automatic logic [15:0] rol(input logic [15:0] v, input int s);
        return (v << s) | (v >> (16 - s));
    endfunction

    function automatic logic [15:0] fr(input logic [15:0] v);
        return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
    endfunction

    function automatic logic [511:0] expand(input logic [63:0] key);
        logic [15:0] k [0:31];
        logic [15:0] t;
        logic [511:0] r;
        for (int i = 0; i < 4; i++) k[i] = key[16*i +: 16];
        for (int i = 4; i < 32; i++) begin
            t = rol(k[i-1], 13) ^ k[i-3];
            t = t ^ rol(t, 15);
            k[i] = ~k[i-4] ^ t ^ {15'd0, ZSEQ[61-(i-4)]} ^ 16'd3;
        end
        for (int i = 0; i < 32; i++) r[16*i +: 16] = k[i];
        return r;
    endfunction

    function automatic logic [31:0] enc(input logic [31:0] pt, input logic [63:0] key);
        logic [511:0] ks;
        logic [15:0] x, y, t;
        ks = expand(key);
        x = pt[31:16];
        y = pt[15:0];
        for (int i = 0; i < 32; i++) begin
            t = x;
            x = y ^ fr(x) ^ ks[16*i +: 16];
            y = t;
        end
        return {x, y};
    endfunction

    function automatic logic [31:0] dec(input logic [31:0] ct, input logic [63:0] key);
        logic [511:0] ks;
        logic [15:0] x, y, t;
        ks = expand(key);
        x = ct[31:16];
        y = ct[15:0];
        for (int i = 31; i >= 0; i--) begin
            t = y;
            y = x ^ fr(y) ^ ks[16*i +: 16];
            x = t;
        end
        return {x, y};
    endfunction

    // Monitor: on completion pop the expectation and check the busy length, then
    // collect the 8 ciphertext nibbles and the 16 key nibbles shifted out after it
    initial begin : monitor
        logic        sh;
        logic        prev_done;
        int          busy_cnt;
        int          ncol;
        logic [95:0] cap;
        exp_t        cur;
        prev_done = 1'b0;
        busy_cnt  = 0;
        ncol      = -1;
        cap       = '0;
        forever begin
            @(posedge clk);
            sh = shift;
            @(negedge clk);
            if (!rst_n) begin
                busy_cnt  = 0;
                ncol      = -1;
                prev_done = 1'b0;
                continue;
            end
            if (busy) busy_cnt++;
            if (done && !prev_done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done got=1 want=0");
                    ncol = -1;
                end else begin
                    cur = exp_q.pop_front();
                    chk("busy_cycles", 96'(busy_cnt), 96'(cur.busy));
                    cap  = {92'd0, data_out};
                    ncol = 1;
                end
                busy_cnt = 0;
            end else if (ncol > 0 && sh) begin
                cap = {cap[91:0], data_out};
                ncol++;
                if (ncol == 8) begin
                    chk("ciphertext", 96'(cap[31:0]), 96'(cur.ct));
                    chk("loopback_pt", 96'(dec(cap[31:0], cur.key)), 96'(cur.pt));
                end
                if (ncol == 24) begin
                    chk("key_after_ct", 96'(cap[63:0]), 96'(cur.key));
                    ncol = -1;
                end
            end
            prev_done = done;
        end
    end

    task automatic load_block(input logic [31:0] pt, input logic [63:0] key);
        logic [95:0] v;
        v = {pt, key};
        for (int i = 0; i < 24; i++) begin
            @(posedge clk); #1;
            shift   = 1'b1;
            data_in = v[95-4*i -: 4];
        end
        @(posedge clk); #1;
        shift   = 1'b0;
        data_in = 4'd0;
    endtask

    task automatic wait_done(input string name);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout got=0 want=1", name);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        exp_t e;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_data_out", 96'(data_out), 96'd0);
        chk("reset_busy", 96'(busy), 96'd0);
        chk("reset_done", 96'(done), 96'd0);
        rst_n = 1'b1;

        // Known-answer block
        e = '{pt: PT1, key: KEY, ct: CT1, busy: BUSY_CYC};
        exp_q.push_back(e);
        load_block(PT1, KEY);
        wait_done("kat");

        // Back-to-back: zero plaintext, loaded while the KAT result shifts out
        e = '{pt: 32'h0, key: KEY, ct: enc(32'h0, KEY), busy: BUSY_CYC};
        exp_q.push_back(e);
        load_block(32'h0, KEY);
        wait_done("b2b");

        // shift pulse during RUN is ignored
        e = '{pt: PT1, key: KEY, ct: CT1, busy: BUSY_CYC};
        exp_q.push_back(e);
        load_block(PT1, KEY);
        repeat (5) @(posedge clk);
        #1;
        shift   = 1'b1;
        data_in = 4'hf;
        @(posedge clk); #1;
        shift   = 1'b0;
        data_in = 4'd0;
        wait_done("pulse");

        // Reset around round 10 aborts the run; nothing is expected from it
        load_block(PT1, KEY);
        repeat (11) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrun_rst_data_out", 96'(data_out), 96'd0);
        chk("midrun_rst_busy", 96'(busy), 96'd0);
        chk("midrun_rst_done", 96'(done), 96'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Full reload after the abort
        e = '{pt: PT1, key: KEY, ct: CT1, busy: BUSY_CYC};
        exp_q.push_back(e);
        load_block(PT1, KEY);
        wait_done("after_rst");

        // Shift out the last result, then reset instead of starting another run
        for (int i = 0; i < 23; i++) begin
            @(posedge clk); #1;
            shift   = 1'b1;
            data_in = 4'd0;
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        shift = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pending_expectations", 96'(exp_q.size()), 96'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
